// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fetch and data stages share one memory port.
// Round-robin on contention, bounded wait per access with timeout abort.
module mem_arbiter #(
  parameter int ASIZE   = 16,
  parameter int DSIZE   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [ASIZE-1:0] if_addr,
  output logic             if_done,
  output logic [DSIZE-1:0] if_data,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [ASIZE-1:0] d_addr,
  input  logic [DSIZE-1:0] d_wdata,
  output logic             d_done,
  output logic [DSIZE-1:0] d_rdata,
  output logic             err,
  output logic             busy,
  output logic [ASIZE-1:0] iaddr,
  output logic [ASIZE-1:0] daddr,
  output logic             read,
  output logic             wen,
  output logic [DSIZE-1:0] data_in,
  input  logic [DSIZE-1:0] data_out,
  input  logic             ready,
  input  logic             instruction_ready,
  input  logic             data_ready
);

  typedef enum logic [1:0] {IDLE, IWAIT, DWAIT, WWAIT} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             prio_d_q;
  logic             if_done_q, d_done_q, err_q;
  logic [DSIZE-1:0] if_data_q, d_rdata_q, data_in_q;
  logic [ASIZE-1:0] iaddr_q, daddr_q;
  logic             read_q, wen_q;

  logic grant_d, can_grant, flag, tmo;

  assign grant_d   = d_req && (!if_req || prio_d_q);
  // No grant while a done pulse is out, so IDLE always lasts a cycle.
  assign can_grant = !(if_done_q || d_done_q);
  assign tmo       = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    flag = 1'b0;
    case (state_q)
      IWAIT:   flag = instruction_ready;
      DWAIT:   flag = data_ready;
      WWAIT:   flag = ready;
      default: flag = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prio_d_q  <= 1'b1;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      if_data_q <= '0;
      d_rdata_q <= '0;
      data_in_q <= '1;
      iaddr_q   <= '0;
      daddr_q   <= '0;
      read_q    <= 1'b0;
      wen_q     <= 1'b1;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (can_grant && (if_req || d_req)) begin
            cnt_q <= '0;
            if (grant_d) begin
              daddr_q  <= d_addr;
              read_q   <= 1'b1;
              prio_d_q <= 1'b0;
              // d_we is captured in the choice of wait state.
              if (d_we) begin
                data_in_q <= d_wdata;
                wen_q     <= 1'b0;
                state_q   <= WWAIT;
              end else begin
                state_q   <= DWAIT;
              end
            end else begin
              iaddr_q  <= if_addr;
              read_q   <= 1'b0;
              prio_d_q <= 1'b1;
              state_q  <= IWAIT;
            end
          end
        end
        IWAIT, DWAIT, WWAIT: begin
          if (flag || tmo) begin
            state_q   <= IDLE;
            wen_q     <= 1'b1;
            if_done_q <= (state_q == IWAIT);
            d_done_q  <= (state_q != IWAIT);
            err_q     <= !flag;
            if (flag && state_q == IWAIT) if_data_q <= data_out;
            if (flag && state_q == DWAIT) d_rdata_q <= data_out;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_done = if_done_q;
  assign d_done  = d_done_q;
  assign err     = err_q;
  assign if_data = if_data_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != IDLE);
  assign iaddr   = iaddr_q;
  assign daddr   = daddr_q;
  assign read    = read_q;
  assign wen     = wen_q;
  assign data_in = data_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single accesses plus hand-written
// reset-abort, idle-flag and round-robin sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_done, d_done, err, busy, read, wen;
  logic [15:0] if_data, d_rdata, iaddr, daddr, data_in, data_out;
  logic        ready, instruction_ready, data_ready;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] mem_model [logic [15:0]];

  always #5 clk = ~clk;

  mem_arbiter #(.ASIZE(16), .DSIZE(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .err(err), .busy(busy),
    .iaddr(iaddr), .daddr(daddr), .read(read), .wen(wen), .data_in(data_in),
    .data_out(data_out), .ready(ready), .instruction_ready(instruction_ready),
    .data_ready(data_ready)
  );

  typedef struct {
    int          op;       // 0 fetch, 1 load, 2 store
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdata;    // fetch return word
    int          lat;      // wait cycle that raises the flag, 0 = never
    logic [15:0] exp_data; // if_data for fetch, d_rdata otherwise
    logic        exp_err;
    int          exp_lat;  // cycles from request to visible done
    string       nm;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [15:0] bus, rd;
    int          got;
    bit          unstable;
    @(negedge clk);
    if_req  = (v.op == 0);
    d_req   = (v.op != 0);
    d_we    = (v.op == 2);
    if_addr = v.addr;
    d_addr  = v.addr;
    d_wdata = v.wdata;
    @(negedge clk);
    bus = (v.op == 0) ? iaddr : daddr;
    chk({v.nm, "_grant"}, {busy, read, wen, bus}, {1'b1, (v.op != 0), (v.op != 2), v.addr});
    if (v.op == 2) chk({v.nm, "_wdata"}, data_in, v.wdata);
    if_req  = 1'b0;
    d_req   = 1'b0;
    if_addr = ~v.addr;
    d_addr  = ~v.addr;
    d_wdata = ~v.wdata;
    d_we    = ~d_we;
    got = -1;
    unstable = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      bus = (v.op == 0) ? iaddr : daddr;
      if ({read, wen, bus} !== {(v.op != 0), (v.op != 2), v.addr} ||
          (v.op == 2 && data_in !== v.wdata)) unstable = 1'b1;
      data_out = 16'hDEAD;
      if (v.lat == k) begin
        case (v.op)
          0: begin instruction_ready = 1'b1; data_out = v.mdata; end
          1: begin
               data_ready = 1'b1;
               data_out = mem_model.exists(daddr) ? mem_model[daddr] : 16'h0000;
             end
          default: begin ready = 1'b1; mem_model[daddr] = data_in; end
        endcase
      end
      @(negedge clk);
      instruction_ready = 1'b0;
      data_ready = 1'b0;
      ready = 1'b0;
      data_out = 16'hDEAD;
      if (if_done || d_done) begin got = k + 1; break; end
    end
    chk({v.nm, "_latency"}, got, v.exp_lat);
    chk({v.nm, "_stable"}, {31'd0, unstable}, 32'd0);
    chk({v.nm, "_done"}, {if_done, d_done, err}, {(v.op == 0), (v.op != 0), v.exp_err});
    rd = (v.op == 0) ? if_data : d_rdata;
    chk({v.nm, "_data"}, rd, v.exp_data);
    chk({v.nm, "_idle"}, {busy, wen}, 2'b01);
    @(negedge clk);
    chk({v.nm, "_pulse"}, {if_done, d_done, err}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gnt;
    int         nacc, ng, since_done;
    bit         prev_busy, gap_bad;
    vec_t       refetch;

    tbl[0] = '{0, 16'h0010, 16'h0000, 16'hABCD, 3,  16'hABCD, 1'b0, 4,  "fetch"};
    tbl[1] = '{2, 16'h0020, 16'h1234, 16'h0000, 3,  16'h0000, 1'b0, 4,  "store"};
    tbl[2] = '{1, 16'h0020, 16'h0000, 16'h0000, 3,  16'h1234, 1'b0, 4,  "load"};
    tbl[3] = '{1, 16'h0030, 16'h0000, 16'h0000, 0,  16'h1234, 1'b1, 16, "load_tmo"};
    tbl[4] = '{0, 16'h0044, 16'h0000, 16'h5A5A, 1,  16'h5A5A, 1'b0, 2,  "fetch_fast"};
    tbl[5] = '{0, 16'h0046, 16'h0000, 16'h1111, 0,  16'h5A5A, 1'b1, 16, "fetch_tmo"};
    tbl[6] = '{2, 16'h0030, 16'hBEEF, 16'h0000, 15, 16'h1234, 1'b0, 16, "store_edge"};
    tbl[7] = '{1, 16'h0030, 16'h0000, 16'h0000, 2,  16'hBEEF, 1'b0, 3,  "load_back"};
    tbl[8] = '{2, 16'h0050, 16'h0F0F, 16'h0000, 0,  16'hBEEF, 1'b1, 16, "store_tmo"};

    rst = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    data_out = 16'hDEAD; ready = 1'b0; instruction_ready = 1'b0; data_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_pulses", {if_done, d_done, err, busy}, 4'b0000);
    chk("rst_ctrl", {wen, read}, 2'b10);
    chk("rst_addr", {iaddr, daddr}, 32'h0);
    chk("rst_data_in", data_in, 16'hFFFF);
    chk("rst_data", {if_data, d_rdata}, 32'h0);
    rst = 1'b1;

    // Completion flags while idle must do nothing.
    @(negedge clk);
    instruction_ready = 1'b1; data_ready = 1'b1; ready = 1'b1; data_out = 16'h7777;
    repeat (2) @(negedge clk);
    chk("idle_flags", {if_done, d_done, err, busy}, 4'b0000);
    chk("idle_flag_data", {if_data, d_rdata}, 32'h0);
    instruction_ready = 1'b0; data_ready = 1'b0; ready = 1'b0; data_out = 16'hDEAD;

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // Reset in the second IWAIT cycle abandons the fetch.
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0300;
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    chk("rmid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rmid_ctrl", {busy, if_done, err, wen, read}, 5'b00010);
    chk("rmid_addr", {iaddr, daddr}, 32'h0);
    chk("rmid_data", {if_data, d_rdata, data_in}, {32'h0, 16'hFFFF});
    instruction_ready = 1'b1; data_out = 16'h9999;
    @(negedge clk);
    chk("rmid_nodone", {31'd0, if_done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    instruction_ready = 1'b0; data_out = 16'hDEAD;
    chk("rmid_after", {if_done, busy, if_data}, 18'h0);
    refetch = '{0, 16'h0300, 16'h0000, 16'h4242, 3, 16'h4242, 1'b0, 4, "refetch"};
    run_txn(refetch);

    // Both requesters held high: grants must alternate D, I, D, I.
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    nacc = 0; ng = 0; since_done = -1; prev_busy = 1'b0; gap_bad = 1'b0; gnt = '0;
    for (int cyc = 0; cyc < 80 && nacc < 4; cyc++) begin
      @(negedge clk);
      if (if_done || d_done) begin
        nacc++;
        since_done = 0;
      end else if (since_done == 0) begin
        if (busy) gap_bad = 1'b1;
        since_done = -1;
      end
      if (busy && !prev_busy) begin
        if (ng < 4) gnt[3-ng] = read;
        ng++;
      end
      prev_busy = busy;
      instruction_ready = busy && !read;
      data_ready = busy && read;
      data_out = 16'h1000 + 16'(cyc);
    end
    if_req = 1'b0; d_req = 1'b0;
    instruction_ready = 1'b0; data_ready = 1'b0; data_out = 16'hDEAD;
    chk("rr_count", nacc, 4);
    chk("rr_order", {28'd0, gnt}, 32'b1010);
    chk("rr_gap", {31'd0, gap_bad}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
